pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV pipeline; sits beside the EX-stage operand forwarding unit and drives PC and pipeline-register enables/bubbles.
- Resolves:
  - load-use hazards that forwarding cannot cover;
  - EX-stage control redirects;
  - instruction-fetch misses;
  - multi-cycle data-memory waits, with a timeout.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl_if.sv | 43 ++++
 rtl/pipeline_hazard_ctrl_hazard_decode.sv | 47 ++++
 rtl/pipeline_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Opcode constants and sequencer state encoding shared by the
//               hazard control logic of the 5-stage RV pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam logic [6:0] c_OP_MATHR  = 7'b0110011;
    localparam logic [6:0] c_OP_MATHWR = 7'b0111011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_SW     = 7'b0100011;
    localparam logic [6:0] c_OP_LW     = 7'b0000011;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Pipeline-side bundle of the hazard sequencer: ID/EX hazard
//               inputs, memory handshakes, enables, bubbles and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
    logic [31:0] IDinst;
    logic [4:0]  EXrd;
    logic        EXwe_reg;
    logic        EXre_mem;
    logic        br_taken;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_ack;
    logic        pc_we;
    logic        IFID_we;
    logic        IDEX_we;
    logic        EXMEM_we;
    logic        MEMWB_we;
    logic        IDflush;
    logic        EXflush;
    logic        WBflush;
    logic        mem_err;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] wait_cnt;

    modport master (
        output IDinst, EXrd, EXwe_reg, EXre_mem, br_taken, imem_ack, dmem_req, dmem_ack,
        input  pc_we, IFID_we, IDEX_we, EXMEM_we, MEMWB_we, IDflush, EXflush, WBflush,
        input  mem_err, state, stall_cnt, flush_cnt, wait_cnt
    );

    modport slave (
        input  IDinst, EXrd, EXwe_reg, EXre_mem, br_taken, imem_ack, dmem_req, dmem_ack,
        output pc_we, IFID_we, IDEX_we, EXMEM_we, MEMWB_we, IDflush, EXflush, WBflush,
        output mem_err, state, stall_cnt, flush_cnt, wait_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_decode.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_hazard_decode
// Description : Combinational source-register usage decode of the ID
//               instruction and the load-use compare against the EX load.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl_hazard_decode
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_we_reg,
    input  logic        i_ex_re_mem,
    output logic        o_load_use
);

    logic [6:0] w_opcode;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic       w_unused_inst;

    assign w_opcode      = i_inst[6:0];
    assign w_rs1         = i_inst[19:15];
    assign w_rs2         = i_inst[24:20];
    assign w_unused_inst = ^{i_inst[31:25], i_inst[14:7]};

    always_comb begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        case (w_opcode)
            c_OP_JAL, c_OP_LUI, c_OP_AUIPC:              w_rs1_used = 1'b0;
            c_OP_MATHR, c_OP_MATHWR, c_OP_BRANCH, c_OP_SW: w_rs2_used = 1'b1;
            c_OP_LW:                                     w_rs1_used = 1'b1;
            default:                                     ;
        endcase
    end

    // x0 is never a real producer, so a load targeting it cannot create a hazard
    assign o_load_use = i_ex_re_mem && i_ex_we_reg && (i_ex_rd != 5'd0) &&
                        ((w_rs1_used && (w_rs1 == i_ex_rd)) ||
                         (w_rs2_used && (w_rs2 == i_ex_rd)));

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for the 5-stage RV pipeline (load-use,
//               redirects, fetch misses, data-memory waits with timeout).
//               Define PERF_CNT_EN to build the saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] c_ONE     = TO_W'(1);

    state_t          r_state;
    state_t          w_next_state;
    logic [TO_W-1:0] r_wait_cnt;
    logic [TO_W-1:0] w_wait_cnt_nxt;
    logic            r_mem_err;
    logic            w_mem_err_nxt;

    logic w_load_use;
    logic w_dmem_stall;
    logic w_release;
    logic w_freeze;
    logic w_full_freeze;
    logic w_run_pc_we;
    logic w_run_ifid_we;
    logic w_run_idflush;
    logic w_run_exflush;
    logic w_run_redirect;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_idex_we;
    logic w_exmem_we;
    logic w_memwb_we;
    logic w_idflush;
    logic w_exflush;
    logic w_wbflush;
    logic w_redirect;

    pipeline_hazard_ctrl_hazard_decode u_hazard_decode (
        .i_inst      (bus.IDinst),
        .i_ex_rd     (bus.EXrd),
        .i_ex_we_reg (bus.EXwe_reg),
        .i_ex_re_mem (bus.EXre_mem),
        .o_load_use  (w_load_use)
    );

    assign w_dmem_stall = bus.dmem_req && !bus.dmem_ack;

    // Unfrozen behaviour; a redirect squashes the load-use consumer so no stall is added
    always_comb begin
        w_run_pc_we    = 1'b1;
        w_run_ifid_we  = 1'b1;
        w_run_idflush  = 1'b0;
        w_run_exflush  = 1'b0;
        w_run_redirect = 1'b0;
        if (bus.br_taken) begin
            w_run_idflush  = 1'b1;
            w_run_exflush  = 1'b1;
            w_run_redirect = 1'b1;
        end else if (w_load_use) begin
            w_run_pc_we   = 1'b0;
            w_run_ifid_we = 1'b0;
            w_run_exflush = 1'b1;
        end else if (!bus.imem_ack) begin
            w_run_pc_we   = 1'b0;
            w_run_idflush = 1'b1;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        w_release      = 1'b0;
        w_freeze       = 1'b0;
        w_full_freeze  = 1'b0;
        w_pc_we        = 1'b1;
        w_ifid_we      = 1'b1;
        w_idex_we      = 1'b1;
        w_exmem_we     = 1'b1;
        w_memwb_we     = 1'b1;
        w_idflush      = 1'b0;
        w_exflush      = 1'b0;
        w_wbflush      = 1'b0;
        w_redirect     = 1'b0;

        // While reset is held the pipeline sees plain pass-through enables
        if (rstn) begin
            case (r_state)
                RUN: begin
                    if (w_dmem_stall) begin
                        w_freeze       = 1'b1;
                        w_next_state   = MEM_WAIT;
                        w_wait_cnt_nxt = c_ONE;
                    end else begin
                        w_release = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ack) begin
                        w_release      = 1'b1;
                        w_next_state   = RUN;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        w_freeze = 1'b1;
                        if (r_wait_cnt == c_TIMEOUT) begin
                            w_mem_err_nxt = 1'b1;
                            w_next_state  = MEM_ERR;
                        end else begin
                            w_wait_cnt_nxt = r_wait_cnt + c_ONE;
                        end
                    end
                end
                MEM_ERR: begin
                    w_freeze      = 1'b1;
                    w_full_freeze = 1'b1;
                end
                default: w_next_state = RUN;
            endcase
        end

        if (w_release) begin
            w_pc_we    = w_run_pc_we;
            w_ifid_we  = w_run_ifid_we;
            w_idflush  = w_run_idflush;
            w_exflush  = w_run_exflush;
            w_redirect = w_run_redirect;
        end else if (w_freeze) begin
            w_pc_we    = 1'b0;
            w_ifid_we  = 1'b0;
            w_idex_we  = 1'b0;
            w_exmem_we = 1'b0;
            w_memwb_we = !w_full_freeze;
            w_wbflush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    assign bus.pc_we    = w_pc_we;
    assign bus.IFID_we  = w_ifid_we;
    assign bus.IDEX_we  = w_idex_we;
    assign bus.EXMEM_we = w_exmem_we;
    assign bus.MEMWB_we = w_memwb_we;
    assign bus.IDflush  = w_idflush;
    assign bus.EXflush  = w_exflush;
    assign bus.WBflush  = w_wbflush;
    assign bus.mem_err  = r_mem_err;
    assign bus.state    = r_state;

`ifdef PERF_CNT_EN
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_perf_wait_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
            r_perf_wait_cnt <= '0;
        end else begin
            if (!w_pc_we && (r_stall_cnt != c_CNT_MAX))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_redirect && (r_flush_cnt != c_CNT_MAX))
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if ((r_state == MEM_WAIT) && (r_perf_wait_cnt != c_CNT_MAX))
                r_perf_wait_cnt <= r_perf_wait_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
    assign bus.wait_cnt  = r_perf_wait_cnt;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
    assign bus.wait_cnt  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4);
//               per-cycle expected outputs flow through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [31:0] inst;
        logic [4:0]  exrd;
        logic        exwe;
        logic        exre;
        logic        br;
        logic        imem;
        logic        dreq;
        logic        dack;
    } stim_t;

    // {pc_we, IFID_we, IDEX_we, EXMEM_we, MEMWB_we, IDflush, EXflush, WBflush}
    localparam logic [7:0] c_P_NORM = 8'b11111_000;
    localparam logic [7:0] c_P_LU   = 8'b00111_010;
    localparam logic [7:0] c_P_BR   = 8'b11111_110;
    localparam logic [7:0] c_P_IM   = 8'b01111_100;
    localparam logic [7:0] c_P_FRZ  = 8'b00001_001;
    localparam logic [7:0] c_P_ERR  = 8'b00000_001;

    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_ADD_X5   = {7'd0, 5'd1, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] c_ADD_X0   = {7'd0, 5'd1, 5'd0, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] c_LUI_X5   = {7'd0, 5'd5, 5'd5, 3'd0, 5'd5, 7'b0110111};
    localparam logic [31:0] c_JAL      = {7'd0, 5'd5, 5'd5, 3'd0, 5'd1, 7'b1101111};
    localparam logic [31:0] c_SW_X5    = {7'd0, 5'd5, 5'd2, 3'd2, 5'd0, 7'b0100011};
    localparam logic [31:0] c_ADDI_IMM = {7'd0, 5'd5, 5'd3, 3'd0, 5'd7, 7'b0010011};

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;
    logic [10:0] exp_q[$];

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .TO_W        (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [31:0] inst, input logic [4:0] rd,
                                 input logic we, input logic re, input logic br,
                                 input logic im, input logic rq, input logic ak);
        stim_t s;
        s = '{inst: inst, exrd: rd, exwe: we, exre: re, br: br, imem: im, dreq: rq, dack: ak};
        return s;
    endfunction

    function automatic logic [10:0] ex(input logic [1:0] st, input logic err, input logic [7:0] p);
        return {st, err, p};
    endfunction

    function automatic logic [10:0] outs();
        return {bus.state, bus.mem_err, bus.pc_we, bus.IFID_we, bus.IDEX_we, bus.EXMEM_we,
                bus.MEMWB_we, bus.IDflush, bus.EXflush, bus.WBflush};
    endfunction

    task automatic apply(input stim_t s);
        bus.IDinst   = s.inst;
        bus.EXrd     = s.exrd;
        bus.EXwe_reg = s.exwe;
        bus.EXre_mem = s.exre;
        bus.br_taken = s.br;
        bus.imem_ack = s.imem;
        bus.dmem_req = s.dreq;
        bus.dmem_ack = s.dack;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        logic [10:0] e;
        apply(mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(ex(2'd0, 1'b0, c_P_NORM));
        @(negedge clk);
        got = outs();
        e   = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", got, e);
        end
        n_tests++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        apply(mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    endtask

    task automatic test_load_use();
        stim_t st[3];
        logic [10:0] e[3];
        logic [10:0] got;
        logic [10:0] want;
        st[0] = mk(c_ADD_X5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); e[0] = ex(2'd0, 1'b0, c_P_LU);
        st[1] = mk(c_ADD_X5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); e[1] = ex(2'd0, 1'b0, c_P_NORM);
        st[2] = mk(c_SW_X5,  5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); e[2] = ex(2'd0, 1'b0, c_P_LU);
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_stall();
        stim_t st[5];
        logic [10:0] got;
        logic [10:0] want;
        st[0] = mk(c_LUI_X5,   5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        st[1] = mk(c_JAL,      5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        st[2] = mk(c_ADD_X0,   5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        st[3] = mk(c_ADDI_IMM, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        st[4] = mk(c_ADD_X5,   5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            exp_q.push_back(ex(2'd0, 1'b0, c_P_NORM));
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL no_stall[%0d]: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_br_load_use();
        stim_t st[2];
        logic [10:0] e[2];
        logic [10:0] got;
        logic [10:0] want;
        logic [31:0] f0;
        f0 = bus.flush_cnt;
        st[0] = mk(c_ADD_X5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); e[0] = ex(2'd0, 1'b0, c_P_BR);
        st[1] = mk(c_NOP,    5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); e[1] = ex(2'd0, 1'b0, c_P_NORM);
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL br_load_use[%0d]: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
`ifdef PERF_CNT_EN
        n_tests++;
        if (bus.flush_cnt !== f0 + 32'd1) begin
            n_fail++;
            $display("FAIL flush_cnt_delta: got %0d expected %0d", bus.flush_cnt - f0, 1);
        end
`endif
    endtask

    task automatic test_mem_wait();
        stim_t st[5];
        logic [10:0] e[5];
        logic [10:0] got;
        logic [10:0] want;
        logic [31:0] s0;
        logic [31:0] w0;
        s0 = bus.stall_cnt;
        w0 = bus.wait_cnt;
        st[0] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); e[0] = ex(2'd0, 1'b0, c_P_FRZ);
        st[1] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); e[1] = ex(2'd1, 1'b0, c_P_FRZ);
        st[2] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0); e[2] = ex(2'd1, 1'b0, c_P_FRZ);
        st[3] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); e[3] = ex(2'd1, 1'b0, c_P_BR);
        st[4] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); e[4] = ex(2'd0, 1'b0, c_P_NORM);
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mem_wait[%0d]: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
`ifdef PERF_CNT_EN
        n_tests++;
        if (bus.wait_cnt !== w0 + 32'd3) begin
            n_fail++;
            $display("FAIL wait_cnt_delta: got %0d expected %0d", bus.wait_cnt - w0, 3);
        end
        n_tests++;
        if (bus.stall_cnt !== s0 + 32'd3) begin
            n_fail++;
            $display("FAIL stall_cnt_delta: got %0d expected %0d", bus.stall_cnt - s0, 3);
        end
`endif
    endtask

    task automatic test_back_to_back();
        stim_t st[6];
        logic [10:0] e[6];
        logic [10:0] got;
        logic [10:0] want;
        st[0] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); e[0] = ex(2'd0, 1'b0, c_P_FRZ);
        st[1] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); e[1] = ex(2'd1, 1'b0, c_P_NORM);
        st[2] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); e[2] = ex(2'd0, 1'b0, c_P_FRZ);
        st[3] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); e[3] = ex(2'd1, 1'b0, c_P_NORM);
        st[4] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); e[4] = ex(2'd0, 1'b0, c_P_NORM);
        st[5] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); e[5] = ex(2'd0, 1'b0, c_P_NORM);
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imem_miss();
        stim_t st[5];
        logic [10:0] e[5];
        logic [10:0] got;
        logic [10:0] want;
        st[0] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); e[0] = ex(2'd0, 1'b0, c_P_IM);
        st[1] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); e[1] = ex(2'd0, 1'b0, c_P_IM);
        st[2] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); e[2] = ex(2'd0, 1'b0, c_P_FRZ);
        st[3] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); e[3] = ex(2'd1, 1'b0, c_P_IM);
        st[4] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); e[4] = ex(2'd0, 1'b0, c_P_NORM);
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL imem_miss[%0d]: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [10:0] got;
        logic [10:0] want;
        for (int i = 0; i < 3; i++) begin
            apply(mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
            exp_q.push_back(ex((i == 0) ? 2'd0 : 2'd1, 1'b0, c_P_FRZ));
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mid_wait_enter[%0d]: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        #2;
        rstn = 1'b0;
        exp_q.push_back(ex(2'd0, 1'b0, c_P_NORM));
        #1;
        got  = outs();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL mid_wait_reset: got %b expected %b", got, want);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        apply(mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(ex(2'd0, 1'b0, c_P_NORM));
        @(negedge clk);
        got  = outs();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL mid_wait_after: got %b expected %b", got, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        stim_t st[8];
        logic [10:0] e[8];
        logic [10:0] got;
        logic [10:0] want;
        for (int i = 0; i < 8; i++) begin
            st[i] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            e[i]  = ex(2'd1, 1'b0, c_P_FRZ);
        end
        e[0]  = ex(2'd0, 1'b0, c_P_FRZ);
        e[5]  = ex(2'd2, 1'b1, c_P_ERR);
        st[6] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        e[6]  = ex(2'd2, 1'b1, c_P_ERR);
        st[7] = mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        e[7]  = ex(2'd2, 1'b1, c_P_ERR);
        for (int i = 0; i < 8; i++) begin
            apply(st[i]);
            exp_q.push_back(e[i]);
            @(negedge clk);
            got  = outs();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got %b expected %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({bus.state, bus.mem_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL err_reset: got state=%0d err=%b expected state=0 err=0",
                     bus.state, bus.mem_err);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        apply(mk(c_NOP, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_no_stall();
        test_br_load_use();
        test_mem_wait();
        test_back_to_back();
        test_imem_miss();
        test_reset_mid_wait();
        test_timeout();
`ifndef PERF_CNT_EN
        @(posedge clk); #1;
        n_tests++;
        if ({bus.stall_cnt, bus.flush_cnt, bus.wait_cnt} !== 96'd0) begin
            n_fail++;
            $display("FAIL perf_tied_off: got %0d/%0d/%0d expected 0/0/0",
                     bus.stall_cnt, bus.flush_cnt, bus.wait_cnt);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
